// File: rtl/p_fifo_rm.sv
// p_fifo_rm: byte-granular circular FIFO, up to 31 bytes joined and popped per cycle.
// Define P_FIFO_RM_ZERO_FILL_EN to zero PopData bytes at and above PopAmount.
module p_fifo_rm #(
  parameter int DEPTH_BYTES = 64
) (
  input  logic         i_core_clk,
  input  logic         i_rx_rstn,
  input  logic         JoinEnable,
  output logic         JoinPermit,
  input  logic [4:0]   JoinAmount,
  input  logic [255:0] JoinData,
  input  logic         PopPermit,
  input  logic [4:0]   PopAmount,
  output logic         PopEnable,
  output logic [255:0] PopData
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int LW = AW + 1;
  logic [7:0]    mem [DEPTH_BYTES];
  logic [AW-1:0] wp, rp;
  logic [LW-1:0] level, jamt, pamt;
  logic          join_go, pop_go;
  logic [255:0]  rd;
  assign jamt = LW'(JoinAmount);
  assign pamt = LW'(PopAmount);
  assign JoinPermit = !i_rx_rstn && (LW'(DEPTH_BYTES) - level) >= jamt;
  assign join_go = JoinEnable && JoinPermit && JoinAmount != 5'd0;
  // pop eligibility uses the start-of-cycle level, so same-cycle joins never feed a pop
  assign pop_go = !i_rx_rstn && PopPermit && PopAmount != 5'd0 && level >= pamt;
  always_comb begin
    rd = '0;
    for (int k = 0; k < 32; k++)
`ifdef P_FIFO_RM_ZERO_FILL_EN
      rd[8*k +: 8] = k < int'(PopAmount) ? mem[rp + AW'(k)] : 8'h00;
`else
      rd[8*k +: 8] = mem[rp + AW'(k)];
`endif
  end
  always_ff @(posedge i_core_clk)
    if (join_go)
      for (int k = 0; k < 32; k++)
        if (k < int'(JoinAmount)) mem[wp + AW'(k)] <= JoinData[8*k +: 8];
  always_ff @(posedge i_core_clk) begin
    if (i_rx_rstn) begin
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      PopEnable <= 1'b0;
      PopData   <= '0;
    end else begin
      wp        <= wp + (join_go ? AW'(JoinAmount) : '0);
      rp        <= rp + (pop_go ? AW'(PopAmount) : '0);
      level     <= level + (join_go ? jamt : '0) - (pop_go ? pamt : '0);
      PopEnable <= pop_go;
      if (pop_go) PopData <= rd;
    end
  end
endmodule

// File: tb/tb_p_fifo_rm.sv
// tb_p_fifo_rm: directed checks of p_fifo_rm joins, pops, limits, wrap and reset.
module tb_p_fifo_rm;
  logic         tb_sclk = 1'b0;
  logic         rst = 1'b1;
  logic         join_en = 1'b0, pop_permit = 1'b0;
  logic         join_permit, pop_en;
  logic [4:0]   join_amt = '0, pop_amt = '0;
  logic [255:0] join_data = '0, pop_data;
  int           cmp = 0, errs = 0;
  always #5 tb_sclk = ~tb_sclk;
  p_fifo_rm #(.DEPTH_BYTES(64)) dut (
    .i_core_clk(tb_sclk), .i_rx_rstn(rst),
    .JoinEnable(join_en), .JoinPermit(join_permit), .JoinAmount(join_amt), .JoinData(join_data),
    .PopPermit(pop_permit), .PopAmount(pop_amt), .PopEnable(pop_en), .PopData(pop_data)
  );
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge tb_sclk);
    #1;
  endtask
  function automatic logic [255:0] ramp(input int base);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[8*k +: 8] = 8'(base + k);
    return r;
  endfunction
  function automatic logic [255:0] lomask(input int n);
    logic [255:0] m;
    for (int k = 0; k < 32; k++) m[8*k +: 8] = k < n ? 8'hff : 8'h00;
    return m;
  endfunction
  initial begin
    logic [255:0] exp;
    logic [7:0]   q[$];
    int           mlev, cnt, bad;
    bit           jg, pg;
    // reset held 3 cycles with join and pop requests that must be ignored
    join_en = 1; join_amt = 5; join_data = ramp(0); pop_permit = 1; pop_amt = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_pop_en", 256'(pop_en), 256'(0));
      chk("rst_pop_data", pop_data, '0);
      chk("rst_join_permit", 256'(join_permit), 256'(0));
    end
    rst = 0; join_en = 0; pop_permit = 0; join_amt = 31; #1;
    chk("rel_join_permit", 256'(join_permit), 256'(1));
    chk("rel_level", 256'(dut.level), 256'(0));
    // two joins of 10, then one pop of 19
    join_en = 1; join_amt = 10; join_data = ramp(0); tick;
    join_data = ramp(8'h20); tick;
    join_en = 0; pop_permit = 1; pop_amt = 19; tick;
    exp = '0;
    for (int k = 0; k < 19; k++) exp[8*k +: 8] = k < 10 ? 8'(k) : 8'(8'h20 + k - 10);
    chk("p19_en", 256'(pop_en), 256'(1));
    chk("p19_data", pop_data & lomask(19), exp);
    chk("p19_level", 256'(dut.level), 256'(1));
`ifdef P_FIFO_RM_ZERO_FILL_EN
    chk("p19_zero_fill", pop_data & ~lomask(19), '0);
`endif
    pop_permit = 0; tick;
    chk("p19_idle_en", 256'(pop_en), 256'(0));
    chk("p19_hold", pop_data & lomask(19), exp);
    // pop larger than level is refused
    pop_permit = 1; pop_amt = 2; tick;
    chk("short_pop_en", 256'(pop_en), 256'(0));
    chk("short_pop_level", 256'(dut.level), 256'(1));
    // mid-operation reset discards data and suppresses the strobe
    rst = 1; join_en = 1; join_amt = 1; pop_amt = 1; tick;
    chk("mid_rst_level", 256'(dut.level), 256'(0));
    chk("mid_rst_pop_en", 256'(pop_en), 256'(0));
    // bytes joined this cycle are not poppable this cycle
    rst = 0; join_amt = 5; join_data = ramp(0); pop_amt = 5; tick;
    chk("same_cyc_pop_en", 256'(pop_en), 256'(0));
    chk("same_cyc_level", 256'(dut.level), 256'(5));
    join_en = 0; pop_permit = 0; rst = 1; tick;
    rst = 0;
    // fill to exactly 64 bytes (values 0..63)
    join_en = 1; join_amt = 31; join_data = ramp(0); tick;
    join_data = ramp(31); tick;
    chk("fill62_level", 256'(dut.level), 256'(62));
    chk("fill62_permit", 256'(join_permit), 256'(0));
    join_amt = 2; join_data = ramp(62); #1;
    chk("fill62_permit2", 256'(join_permit), 256'(1));
    tick;
    chk("fill64_level", 256'(dut.level), 256'(64));
    join_amt = 1; #1;
    chk("full_permit1", 256'(join_permit), 256'(0));
    tick;
    chk("full_reject_level", 256'(dut.level), 256'(64));
    join_amt = 0; #1;
    chk("full_permit0", 256'(join_permit), 256'(1));
    join_en = 0;
    // drain to 20 bytes
    pop_permit = 1; pop_amt = 22; tick;
    chk("drain1_en", 256'(pop_en), 256'(1));
    chk("drain1_data", pop_data & lomask(22), ramp(0) & lomask(22));
    tick;
    chk("drain2_data", pop_data & lomask(22), ramp(22) & lomask(22));
    chk("drain2_level", 256'(dut.level), 256'(20));
    // simultaneous join 31 and pop 19 at level 20
    join_en = 1; join_amt = 31; join_data = ramp(64); pop_amt = 19; #1;
    chk("sim_permit", 256'(join_permit), 256'(1));
    tick;
    chk("sim_level", 256'(dut.level), 256'(32));
    chk("sim_pop_en", 256'(pop_en), 256'(1));
    chk("sim_pop_data", pop_data & lomask(19), ramp(44) & lomask(19));
    join_en = 0; pop_permit = 0; tick;
    chk("sim_idle_en", 256'(pop_en), 256'(0));
    // pop across the buffer wrap point
    pop_permit = 1; pop_amt = 31; tick;
    chk("wrap_data", pop_data & lomask(31), ramp(63) & lomask(31));
    chk("wrap_level", 256'(dut.level), 256'(1));
    pop_permit = 0; rst = 1; tick;
    rst = 0;
    // continuous stream: join 31, pop 19, compared against a byte queue
    mlev = 0; cnt = 0; bad = 0;
    for (int c = 0; c < 500; c++) begin
      join_en = 1; join_amt = 31; join_data = ramp(cnt); pop_permit = 1; pop_amt = 19;
      jg = (64 - mlev) >= 31;
      pg = mlev >= 19;
      exp = '0;
      if (pg) for (int k = 0; k < 19; k++) exp[8*k +: 8] = q.pop_front();
      if (jg) begin
        for (int k = 0; k < 31; k++) q.push_back(8'(cnt + k));
        cnt += 31;
      end
      mlev = mlev + (jg ? 31 : 0) - (pg ? 19 : 0);
      #1;
      if (join_permit !== jg) bad++;
      tick;
      if (pop_en !== pg) bad++;
      if (pg && (pop_data & lomask(19)) !== exp) bad++;
      if (int'(dut.level) !== mlev || int'(dut.level) > 64) bad++;
    end
    chk("stream_errors", 256'(bad), 256'(0));
    chk("stream_level", 256'(dut.level), 256'(mlev));
    join_en = 0; pop_permit = 0; rst = 1; tick;
    // short pop of 7 from nonzero data
    rst = 0; join_en = 1; join_amt = 31; join_data = ramp(8'h80); tick;
    join_en = 0; pop_permit = 1; pop_amt = 7; tick;
    pop_permit = 0;
    chk("p7_en", 256'(pop_en), 256'(1));
    chk("p7_data", pop_data & lomask(7), ramp(8'h80) & lomask(7));
    chk("p7_level", 256'(dut.level), 256'(24));
`ifdef P_FIFO_RM_ZERO_FILL_EN
    chk("p7_zero_fill", pop_data & ~lomask(7), '0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/p_fifo_rm.md
P_FIFO_RM -- requirements
Module: p_fifo_rm

Interface
REQ-001 SHALL provide parameter DEPTH_BYTES, default 64, byte capacity of the internal circular buffer; legal values are powers of two and at least 64.
REQ-002 SHALL provide i_core_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide i_rx_rstn  input  1  reset, synchronous and active-high (1 = reset); the name is kept for codebase compatibility.
REQ-004 SHALL provide JoinEnable  input  1  producer requests a write this cycle.
REQ-005 SHALL provide JoinPermit  output  1  buffer can accept JoinAmount bytes this cycle.
REQ-006 SHALL provide JoinAmount  input  5  number of bytes to write, 0..31.
REQ-007 SHALL provide JoinData  input  256  write bytes; byte k = bits [8k+7:8k], byte 0 is oldest.
REQ-008 SHALL provide PopPermit  input  1  consumer ready to take PopAmount bytes.
REQ-009 SHALL provide PopAmount  input  5  number of bytes to read, 0..31.
REQ-010 SHALL provide PopEnable  output  1  registered strobe; PopData is valid this cycle.
REQ-011 SHALL provide PopData  output  256  popped bytes; byte 0 is oldest.

Function
REQ-012 SHALL store a byte-granular FIFO with write pointer, read pointer and a level count 0..DEPTH_BYTES; pointers wrap modulo DEPTH_BYTES.
REQ-013 SHALL drive JoinPermit combinationally as (DEPTH_BYTES - level) >= JoinAmount, using the start-of-cycle level; a pop in the same cycle does not add to free space.
REQ-014 SHALL accept a join when JoinEnable && JoinPermit && JoinAmount != 0: JoinData bytes 0..JoinAmount-1 are written in order at the write pointer, and the write pointer advances by JoinAmount.
REQ-015 SHALL ignore JoinEnable when JoinPermit=0 or JoinAmount=0; no state change results.
REQ-016 SHALL perform a pop when PopPermit && PopAmount != 0 && level >= PopAmount, using the start-of-cycle level; bytes written in the same cycle are not eligible.
REQ-017 SHALL, on a pop, advance the read pointer by PopAmount and in the next cycle assert PopEnable=1 with PopData bytes 0..PopAmount-1 equal to the popped bytes in FIFO order (latency 1).
REQ-018 SHALL drive PopEnable=0 in every cycle not following a pop; PopData holds its last value while PopEnable=0.
REQ-019 SHALL, on a simultaneous join and pop, perform both operations, with level_next = level + JoinAmount - PopAmount.
REQ-020 SHALL sample JoinAmount and PopAmount every cycle; a change takes effect immediately, with no draining required.
REQ-021 SHALL never let level exceed DEPTH_BYTES or go below 0; REQ-013 and REQ-016 enforce this, and no overflow or underflow flags exist.
REQ-022 SHALL preserve exact byte order across pointer wrap-around for any mix of join and pop amounts.

Reset
REQ-023 SHALL, while i_rx_rstn=1 at a clock edge, clear both pointers and level to 0, PopEnable to 0 and PopData to 0; buffer contents need not be cleared.
REQ-024 SHALL force JoinPermit=0 while i_rx_rstn=1 and ignore joins and pops in that cycle; after reset is released, JoinPermit=1 for any JoinAmount.
REQ-025 SHALL discard all stored bytes on a mid-operation reset; no popped strobe follows a reset cycle.

Configuration
REQ-026 SHALL support macro P_FIFO_RM_ZERO_FILL_EN: when defined, PopData bytes PopAmount..31 are 8'h00 on every PopEnable cycle; when undefined, those bytes carry the buffer bytes following the popped bytes (contents unspecified), and consumers use only bytes 0..PopAmount-1.

Verification
REQ-027 SHALL cover: reset held 3 cycles -> PopEnable=0, PopData=0, JoinPermit=0 during reset and 1 after release.
REQ-028 SHALL cover: PopPermit=0, join JoinAmount=10 with bytes k=k, then bytes k=0x20+k; PopAmount=19, PopPermit=1 -> one cycle later PopEnable=1, bytes 0..9=0x00..0x09 and bytes 10..18=0x20..0x28; level 1.
REQ-029 SHALL cover: JoinAmount=31, two joins with no pop -> level 62 and JoinPermit=0; JoinAmount changed to 2 -> JoinPermit=1; a join then gives level 64, and further joins are rejected.
REQ-030 SHALL cover: level 20, same-cycle join 31 and pop 19 -> level 32 next cycle and PopEnable=1 after 1 cycle.
REQ-031 SHALL cover: continuous JoinAmount=31 with incrementing bytes and PopAmount=19 for 500 cycles -> the concatenated popped stream equals the joined stream byte-for-byte across wrap-around, and level stays within 0..64.
REQ-032 SHALL cover: P_FIFO_RM_ZERO_FILL_EN defined, PopAmount=7 -> PopData bytes 7..31 all 0x00.
